// File: rtl/param_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_rx_fifo
// Description : Parametrised first-word-fall-through receive FIFO with
//               occupancy count, watermarks, flush and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module param_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      clr_err,
    input  logic                      w_enable,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic                      r_enable,
    output logic [DATA_WIDTH-1:0]     r_data,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int                 c_ADDR      = $clog2(DEPTH);
    localparam logic [c_ADDR:0]    c_DEPTH_CNT = DEPTH[c_ADDR:0];
    localparam logic [c_ADDR:0]    c_AF        = AF_THRESH[c_ADDR:0];
    localparam logic [c_ADDR:0]    c_AE        = AE_THRESH[c_ADDR:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ADDR-1:0]     r_wr_ptr;
    logic [c_ADDR-1:0]     r_rd_ptr;
    logic [c_ADDR:0]       r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_rd_accept;
    logic w_wr_accept;
    logic w_ovf_set;
    logic w_udf_set;

    // A write into a full FIFO is allowed when a pop frees a slot on the same edge.
    assign w_rd_accept = r_enable && !empty;
    assign w_wr_accept = w_enable && (!full || w_rd_accept);
    assign w_ovf_set   = w_enable && full && !r_enable;
    assign w_udf_set   = r_enable && empty;

    assign empty        = (r_count == '0);
    assign full         = (r_count == c_DEPTH_CNT);
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign r_data       = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && !flush && w_wr_accept) begin
            r_mem[r_wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a set event beats a simultaneous clear; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!flush) begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_rx_fifo
// Description : Directed bench for param_rx_fifo at 8x8 and 16x16 geometries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_rx_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush   [2];
    logic        clr_err [2];
    logic        we      [2];
    logic        re      [2];
    logic [15:0] wd      [2];

    logic [7:0]  rd8;
    logic [15:0] rd16;
    logic [3:0]  cnt8;
    logic [4:0]  cnt16;
    logic [5:0]  fl8;   // {udf, ovf, ae, af, full, empty}
    logic [5:0]  fl16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush[0]), .clr_err(clr_err[0]),
        .w_enable(we[0]), .w_data(wd[0][7:0]), .r_enable(re[0]), .r_data(rd8),
        .empty(fl8[0]), .full(fl8[1]), .almost_full(fl8[2]), .almost_empty(fl8[3]),
        .count(cnt8), .overflow(fl8[4]), .underflow(fl8[5])
    );

    param_rx_fifo #(.DATA_WIDTH(16), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(3)) dut16 (
        .clk(clk), .rst(rst), .flush(flush[1]), .clr_err(clr_err[1]),
        .w_enable(we[1]), .w_data(wd[1]), .r_enable(re[1]), .r_data(rd16),
        .empty(fl16[0]), .full(fl16[1]), .almost_full(fl16[2]), .almost_empty(fl16[3]),
        .count(cnt16), .overflow(fl16[4]), .underflow(fl16[5])
    );

    function automatic logic [15:0] get_rd(int d);
        return (d == 1) ? rd16 : {8'h00, rd8};
    endfunction

    function automatic logic [4:0] get_cnt(int d);
        return (d == 1) ? cnt16 : {1'b0, cnt8};
    endfunction

    function automatic logic get_fl(int d, int idx);
        return (d == 1) ? fl16[idx] : fl8[idx];
    endfunction

    // 16-bit geometry carries a non-zero upper byte to exercise the full width.
    function automatic logic [15:0] dv(int d, logic [7:0] v);
        return (d == 1) ? {8'h5A, v} : {8'h00, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int d, logic [7:0] v);
        we[d] = 1'b1;
        wd[d] = dv(d, v);
        step();
        we[d] = 1'b0;
    endtask

    task automatic pop(int d);
        re[d] = 1'b1;
        step();
        re[d] = 1'b0;
    endtask

    task automatic clear_errs(int d);
        clr_err[d] = 1'b1;
        step();
        clr_err[d] = 1'b0;
    endtask

    task automatic check_marks(int d, int n, int af, int ae);
        check("count",        32'(get_cnt(d)),   32'(n));
        check("almost_full",  32'(get_fl(d, 2)), 32'(n >= af));
        check("almost_empty", 32'(get_fl(d, 3)), 32'(n <= ae));
    endtask

    task automatic fill_and_drain(int d, int depth, int af, int ae, logic [7:0] base);
        for (int i = 1; i <= depth; i++) begin
            wr(d, base + 8'(i));
            check_marks(d, i, af, ae);
        end
        check("full_at_depth", 32'(get_fl(d, 1)), 32'd1);
        for (int i = 1; i <= depth; i++) begin
            check("drain_data", 32'(get_rd(d)), 32'(dv(d, base + 8'(i))));
            pop(d);
            check_marks(d, depth - i, af, ae);
        end
        check("empty_after_drain", 32'(get_fl(d, 0)), 32'd1);
    endtask

    task automatic run(int d, int depth, int af, int ae);
        // Reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_empty", 32'(get_fl(d, 0)), 32'd1);
        check("rst_full",  32'(get_fl(d, 1)), 32'd0);
        check("rst_af",    32'(get_fl(d, 2)), 32'd0);
        check("rst_ae",    32'(get_fl(d, 3)), 32'd1);
        check("rst_ovf",   32'(get_fl(d, 4)), 32'd0);
        check("rst_udf",   32'(get_fl(d, 5)), 32'd0);
        check("rst_count", 32'(get_cnt(d)),   32'd0);
        check("rst_rdata", 32'(get_rd(d)),    32'd0);

        // FWFT
        wr(d, 8'hC3);
        check("fwft_data",  32'(get_rd(d)),    32'(dv(d, 8'hC3)));
        check("fwft_count", 32'(get_cnt(d)),   32'd1);
        check("fwft_empty", 32'(get_fl(d, 0)), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fwft_hold", 32'(get_rd(d)), 32'(dv(d, 8'hC3)));
        end
        pop(d);
        check("fwft_pop_empty", 32'(get_fl(d, 0)), 32'd1);
        check("fwft_pop_rdata", 32'(get_rd(d)),    32'd0);

        // Fill/drain twice to cross the pointer wrap
        fill_and_drain(d, depth, af, ae, 8'h00);
        fill_and_drain(d, depth, af, ae, 8'h10);

        // Overflow at full, then simultaneous read/write at full
        for (int i = 1; i <= depth; i++) wr(d, 8'(i));
        wr(d, 8'h55);
        check("ovf_set",   32'(get_fl(d, 4)), 32'd1);
        check("ovf_count", 32'(get_cnt(d)),   32'(depth));
        check("ovf_head",  32'(get_rd(d)),    32'(dv(d, 8'h01)));
        clear_errs(d);
        check("ovf_clr", 32'(get_fl(d, 4)), 32'd0);
        we[d] = 1'b1;
        re[d] = 1'b1;
        wd[d] = dv(d, 8'hAA);
        step();
        we[d] = 1'b0;
        re[d] = 1'b0;
        check("rw_full_count", 32'(get_cnt(d)),   32'(depth));
        check("rw_full_ovf",   32'(get_fl(d, 4)), 32'd0);
        for (int i = 2; i <= depth; i++) begin
            check("rw_full_data", 32'(get_rd(d)), 32'(dv(d, 8'(i))));
            pop(d);
        end
        check("rw_full_last", 32'(get_rd(d)), 32'(dv(d, 8'hAA)));
        pop(d);
        check("rw_full_empty", 32'(get_fl(d, 0)), 32'd1);

        // Underflow and clear priority
        pop(d);
        check("udf_set",   32'(get_fl(d, 5)), 32'd1);
        check("udf_count", 32'(get_cnt(d)),   32'd0);
        clear_errs(d);
        check("udf_clr", 32'(get_fl(d, 5)), 32'd0);
        clr_err[d] = 1'b1;
        re[d]      = 1'b1;
        step();
        clr_err[d] = 1'b0;
        re[d]      = 1'b0;
        check("udf_set_beats_clr", 32'(get_fl(d, 5)), 32'd1);

        // Empty with simultaneous write and read
        clear_errs(d);
        we[d] = 1'b1;
        re[d] = 1'b1;
        wd[d] = dv(d, 8'h77);
        step();
        we[d] = 1'b0;
        re[d] = 1'b0;
        check("rw_empty_count", 32'(get_cnt(d)),   32'd1);
        check("rw_empty_data",  32'(get_rd(d)),    32'(dv(d, 8'h77)));
        check("rw_empty_udf",   32'(get_fl(d, 5)), 32'd1);
        pop(d);

        // Flush with a concurrent write; underflow stays set
        for (int i = 0; i < 5; i++) wr(d, 8'h30 + 8'(i));
        check("pre_flush_count", 32'(get_cnt(d)), 32'd5);
        flush[d] = 1'b1;
        we[d]    = 1'b1;
        wd[d]    = dv(d, 8'h99);
        step();
        flush[d] = 1'b0;
        we[d]    = 1'b0;
        check("flush_count", 32'(get_cnt(d)),   32'd0);
        check("flush_empty", 32'(get_fl(d, 0)), 32'd1);
        check("flush_rdata", 32'(get_rd(d)),    32'd0);
        check("flush_udf",   32'(get_fl(d, 5)), 32'd1);
        check("flush_ovf",   32'(get_fl(d, 4)), 32'd0);
        wr(d, 8'h42);
        check("post_flush_data",  32'(get_rd(d)),  32'(dv(d, 8'h42)));
        check("post_flush_count", 32'(get_cnt(d)), 32'd1);

        // Reset mid-stream drops queued data and sticky flags
        wr(d, 8'h43);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_count", 32'(get_cnt(d)),   32'd0);
        check("rst_mid_udf",   32'(get_fl(d, 5)), 32'd0);
        check("rst_mid_rdata", 32'(get_rd(d)),    32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            flush[i]   = 1'b0;
            clr_err[i] = 1'b0;
            we[i]      = 1'b0;
            re[i]      = 1'b0;
            wd[i]      = '0;
        end
        #2;
        run(0, 8, 7, 1);
        run(1, 16, 12, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
